// File: rtl/activation_unit_param.sv
// Parametrised array of leaky integrate-and-fire channels with per-channel
// thresholds, refractory suppression and a windowed spike counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | window open, steps accepted (busy = 1)
// ST_DONE | final step of a bounded window taken, state frozen until clear
module activation_unit_param #(
    parameter int NUM_CH       = 32,
    parameter int DATA_WIDTH   = 16,
    parameter int COUNT_WIDTH  = 5,
    parameter int REFRAC_WIDTH = 3,
    parameter int LEAK_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      in_current,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      threshold,
    input  logic                              reset_mode,
    input  logic [LEAK_WIDTH-1:0]             leak_shift,
    input  logic [REFRAC_WIDTH-1:0]           refrac_period,
    input  logic [COUNT_WIDTH-1:0]            num_steps,
    output logic                              out_valid,
    output logic [NUM_CH-1:0]                 out_spikes,
    output logic [NUM_CH*COUNT_WIDTH-1:0]     accumulated_spikes,
    output logic                              window_done,
    output logic                              busy
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = COUNT_WIDTH;
    localparam int RW = REFRAC_WIDTH;

    localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    function automatic logic signed [DW+1:0] sext2(input logic signed [DW-1:0] x);
        return {{2{x[DW-1]}}, x};
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[DW-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[DW-1:0];
        end else begin
            return x[DW-1:0];
        end
    endfunction

    state_t                  state_q, state_d;
    logic signed [DW-1:0]    v_q       [NUM_CH];
    logic signed [DW-1:0]    v_d       [NUM_CH];
    logic [RW-1:0]           refr_q    [NUM_CH];
    logic [RW-1:0]           refr_d    [NUM_CH];
    logic [CW-1:0]           cnt_q     [NUM_CH];
    logic [CW-1:0]           cnt_d     [NUM_CH];
    logic [CW-1:0]           step_cnt_q, step_cnt_d;
    logic [CW-1:0]           num_steps_q, num_steps_d;
    logic                    out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]       out_spikes_q, out_spikes_d;
    logic                    window_done_q, window_done_d;

    logic signed [DW-1:0]    cur_w     [NUM_CH];
    logic signed [DW-1:0]    th_w      [NUM_CH];
    logic signed [DW-1:0]    leak_w    [NUM_CH];
    logic signed [DW+1:0]    sum_w     [NUM_CH];
    logic signed [DW-1:0]    v_int_w   [NUM_CH];
    logic signed [DW-1:0]    v_sub_w   [NUM_CH];
    logic [NUM_CH-1:0]       spike_w;
    logic                    accept;

    assign accept = in_valid & (state_q == ST_RUN) & ~clear;

    // Integration runs two guard bits wide so the leak/current sum cannot wrap before saturation.
    always_comb begin
        spike_w = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_w[i]   = $signed(in_current[i*DW +: DW]);
            th_w[i]    = $signed(threshold[i*DW +: DW]);
            leak_w[i]  = (leak_shift == '0) ? '0 : (v_q[i] >>> leak_shift);
            sum_w[i]   = sext2(v_q[i]) - sext2(leak_w[i]) + sext2(cur_w[i]);
            v_int_w[i] = sat(sum_w[i]);
            spike_w[i] = (v_int_w[i] >= th_w[i]);
            v_sub_w[i] = sat(sext2(v_int_w[i]) - sext2(th_w[i]));
        end
    end

    always_comb begin
        state_d       = state_q;
        v_d           = v_q;
        refr_d        = refr_q;
        cnt_d         = cnt_q;
        step_cnt_d    = step_cnt_q;
        num_steps_d   = num_steps_q;
        out_valid_d   = 1'b0;
        out_spikes_d  = '0;
        window_done_d = 1'b0;

        if (clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                v_d[i]    = '0;
                refr_d[i] = '0;
                cnt_d[i]  = '0;
            end
            step_cnt_d  = '0;
            num_steps_d = num_steps;
            state_d     = ST_RUN;
        end else if (accept) begin
            out_valid_d = 1'b1;
            step_cnt_d  = step_cnt_q + CW'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (refr_q[i] != '0) begin
                    refr_d[i] = refr_q[i] - RW'(1);
                end else if (spike_w[i]) begin
                    out_spikes_d[i] = 1'b1;
                    v_d[i]          = reset_mode ? v_sub_w[i] : '0;
                    refr_d[i]       = refrac_period;
                    if (cnt_q[i] != {CW{1'b1}}) begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    v_d[i] = v_int_w[i];
                end
            end
            if ((num_steps_q != '0) && (step_cnt_q == num_steps_q - CW'(1))) begin
                window_done_d = 1'b1;
                state_d       = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_RUN;
            step_cnt_q    <= '0;
            num_steps_q   <= '0;
            out_valid_q   <= 1'b0;
            out_spikes_q  <= '0;
            window_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i]    <= '0;
                refr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            step_cnt_q    <= step_cnt_d;
            num_steps_q   <= num_steps_d;
            out_valid_q   <= out_valid_d;
            out_spikes_q  <= out_spikes_d;
            window_done_q <= window_done_d;
            for (int i = 0; i < NUM_CH; i++) begin
                v_q[i]    <= v_d[i];
                refr_q[i] <= refr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_comb begin
        accumulated_spikes = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            accumulated_spikes[i*CW +: CW] = cnt_q[i];
        end
    end

    assign out_valid   = out_valid_q;
    assign out_spikes  = out_spikes_q;
    assign window_done = window_done_q;
    assign busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_activation_unit_param.sv
// Directed bench for activation_unit_param with 4 channels: table of single
// steps plus hand-written window, saturation and reset sequences.
module tb_activation_unit_param;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int CW  = 5;
    localparam int RW  = 3;
    localparam int LW  = 4;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  clear = 1'b0;
    logic                  in_valid = 1'b0;
    logic [NCH*DW-1:0]     in_current = '0;
    logic [NCH*DW-1:0]     threshold = '0;
    logic                  reset_mode = 1'b0;
    logic [LW-1:0]         leak_shift = '0;
    logic [RW-1:0]         refrac_period = '0;
    logic [CW-1:0]         num_steps = '0;
    logic                  out_valid;
    logic [NCH-1:0]        out_spikes;
    logic [NCH*CW-1:0]     accumulated_spikes;
    logic                  window_done;
    logic                  busy;

    activation_unit_param #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .COUNT_WIDTH(CW),
        .REFRAC_WIDTH(RW), .LEAK_WIDTH(LW)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid),
        .in_current(in_current), .threshold(threshold), .reset_mode(reset_mode),
        .leak_shift(leak_shift), .refrac_period(refrac_period), .num_steps(num_steps),
        .out_valid(out_valid), .out_spikes(out_spikes),
        .accumulated_spikes(accumulated_spikes), .window_done(window_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                clr;
        logic signed [15:0] cur;
        logic signed [15:0] th_lo;
        logic signed [15:0] th_hi;
        bit                mode;
        logic [3:0]        leak;
        logic [2:0]        refr;
        logic [3:0]        spk;
    } vec_t;

    vec_t       vecs[$];
    int         n_pass = 0;
    int         n_tot  = 0;
    logic [4:0] mcnt [NCH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input bit clr, input int cur, input int th_lo, input int th_hi,
                       input bit mode, input int leak, input int refr, input logic [3:0] spk);
        vec_t v;
        v.clr = clr; v.cur = 16'(cur); v.th_lo = 16'(th_lo); v.th_hi = 16'(th_hi);
        v.mode = mode; v.leak = 4'(leak); v.refr = 3'(refr); v.spk = spk;
        vecs.push_back(v);
    endtask

    function automatic logic [NCH*CW-1:0] model_acc();
        logic [NCH*CW-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*CW +: CW] = mcnt[i];
        return r;
    endfunction

    task automatic do_clear(input logic [CW-1:0] ns, input logic with_valid);
        @(negedge clk);
        clear = 1'b1; num_steps = ns; in_valid = with_valid;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < NCH; i++) mcnt[i] = '0;
    endtask

    task automatic set_cfg(input int cur, input int th_lo, input int th_hi,
                           input bit mode, input int leak, input int refr);
        for (int i = 0; i < NCH; i++) begin
            in_current[i*DW +: DW] = 16'(cur);
            threshold[i*DW +: DW]  = (i < 2) ? 16'(th_lo) : 16'(th_hi);
        end
        reset_mode = mode; leak_shift = 4'(leak); refrac_period = 3'(refr);
    endtask

    task automatic do_step();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // single-step vectors; clr starts a fresh free-running window
        add(1, 40, 100, 100, 0, 0, 0, 4'b0000);
        add(0, 40, 100, 100, 0, 0, 0, 4'b0000);
        add(0, 40, 100, 100, 0, 0, 0, 4'b1111);
        add(0, 40, 100, 100, 0, 0, 0, 4'b0000);
        add(0, 40, 100, 100, 0, 0, 0, 4'b0000);
        add(0, 40, 100, 100, 0, 0, 0, 4'b1111);
        add(1, 70, 100, 150, 1, 0, 0, 4'b0000);
        add(0, 70, 100, 150, 1, 0, 0, 4'b0011);
        add(0, 70, 100, 150, 1, 0, 0, 4'b1111);
        add(0, 70, 100, 150, 1, 0, 0, 4'b0000);
        add(1, 50, 10, 10, 0, 0, 2, 4'b1111);
        add(0, 50, 10, 10, 0, 0, 2, 4'b0000);
        add(0, 50, 10, 10, 0, 0, 2, 4'b0000);
        add(0, 50, 10, 10, 0, 0, 2, 4'b1111);
        add(1, 64, 1000, 112, 0, 1, 0, 4'b0000);
        add(0, 64, 1000, 112, 0, 1, 0, 4'b0000);
        add(0, 64, 1000, 112, 0, 1, 0, 4'b1100);
        add(0, 64, 1000, 112, 0, 1, 0, 4'b0000);
        add(1, 20000, 32767, 32767, 0, 0, 0, 4'b0000);
        add(0, 20000, 32767, 32767, 0, 0, 0, 4'b1111);
        add(0, 20000, 32767, 32767, 0, 0, 0, 4'b0000);
        add(1, -3, -5, -2, 0, 0, 0, 4'b0011);
        add(0, -3, -5, -2, 0, 0, 0, 4'b0011);

        for (int i = 0; i < NCH; i++) mcnt[i] = '0;
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_acc", 64'(accumulated_spikes), 64'd0);
        chk("reset_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[k]) begin
            set_cfg(vecs[k].cur, vecs[k].th_lo, vecs[k].th_hi,
                    vecs[k].mode, vecs[k].leak, vecs[k].refr);
            if (vecs[k].clr) do_clear('0, 1'b0);
            do_step();
            for (int i = 0; i < NCH; i++)
                if (vecs[k].spk[i] && mcnt[i] != 5'd31) mcnt[i] = mcnt[i] + 5'd1;
            chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_spikes", k), 64'(out_spikes), 64'(vecs[k].spk));
            chk($sformatf("vec%0d_acc", k), 64'(accumulated_spikes), 64'(model_acc()));
            chk($sformatf("vec%0d_done", k), 64'(window_done), 64'd0);
        end

        @(posedge clk); #1;
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_spikes", 64'(out_spikes), 64'd0);

        // bounded window of 3 steps, then 2 ignored steps
        set_cfg(50, 10, 10, 0, 0, 0);
        do_clear(5'd3, 1'b0);
        for (int s = 0; s < 5; s++) begin
            do_step();
            chk($sformatf("win%0d_valid", s), 64'(out_valid), (s < 3) ? 64'd1 : 64'd0);
            chk($sformatf("win%0d_done", s), 64'(window_done), (s == 2) ? 64'd1 : 64'd0);
            chk($sformatf("win%0d_busy", s), 64'(busy), (s < 2) ? 64'd1 : 64'd0);
        end
        chk("win_acc_held", 64'(accumulated_spikes), 64'({4{5'd3}}));

        do_clear('0, 1'b1);
        chk("clr_valid_drop", 64'(out_valid), 64'd0);
        chk("clr_valid_acc", 64'(accumulated_spikes), 64'd0);
        chk("clr_valid_busy", 64'(busy), 64'd1);

        // free-run saturation of the spike counters
        begin
            int done_seen;
            done_seen = 0;
            for (int s = 0; s < 40; s++) begin
                do_step();
                if (window_done) done_seen++;
                if (s == 30) chk("sat_at31", 64'(accumulated_spikes), 64'({4{5'd31}}));
            end
            chk("sat_hold31", 64'(accumulated_spikes), 64'({4{5'd31}}));
            chk("freerun_no_done", 64'(done_seen), 64'd0);
            chk("freerun_busy", 64'(busy), 64'd1);
        end

        // asynchronous reset in the middle of a step cycle
        do_step();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_spikes", 64'(out_spikes), 64'd0);
        chk("rst_acc", 64'(accumulated_spikes), 64'd0);
        chk("rst_done", 64'(window_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rstn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
